// File: rtl/issue_scheduler_pkg.sv
// Shared micro-op and register-ID types for the issue scheduler, plus the
// scoreboard helpers (file-register test, register number, mask, hazard check).
package issue_scheduler_pkg;

   localparam int unsigned REG_FILE_SIZE = 16;
   localparam int unsigned REG_NUM_W     = 4;
   localparam int unsigned REG_ID_W      = 5;
   localparam int unsigned IMM_W         = 16;

   // IDs 0..15 are architectural file registers; the rest are pseudo-registers.
   typedef enum logic [REG_ID_W-1:0] {
      rax = 5'd0,  rcx = 5'd1,  rdx = 5'd2,  rbx = 5'd3,
      rsp = 5'd4,  rbp = 5'd5,  rsi = 5'd6,  rdi = 5'd7,
      r8  = 5'd8,  r9  = 5'd9,  r10 = 5'd10, r11 = 5'd11,
      r12 = 5'd12, r13 = 5'd13, r14 = 5'd14, r15 = 5'd15,
      rnone    = 5'd16,
      rsyscall = 5'd17
   } reg_id_t;

   typedef enum logic [3:0] {
      m_nop, m_add, m_mov, m_ld, m_st, m_clflush, m_jz, m_jmp, m_syscall
   } mopcode_t;

   typedef struct packed {
      mopcode_t             opcode;
      reg_id_t              dst_id;
      reg_id_t              src0_id;
      reg_id_t              src1_id;
      logic [IMM_W-1:0]     imm;
   } micro_op_t;

   function automatic logic is_file_reg(input reg_id_t id);
      logic [REG_ID_W-1:0] v;
      v = id;
      return v < REG_ID_W'(REG_FILE_SIZE);
   endfunction

   function automatic logic [REG_NUM_W-1:0] reg_num(input reg_id_t id);
      logic [REG_ID_W-1:0] v;
      v = id;
      return v[REG_NUM_W-1:0];
   endfunction

   function automatic logic [REG_FILE_SIZE-1:0] make_sb_mask(input reg_id_t id);
      logic [REG_FILE_SIZE-1:0] m;
      m = '0;
      if (is_file_reg(id)) m[reg_num(id)] = 1'b1;
      return m;
   endfunction

   // rsyscall acts as a barrier: it only passes once every writer has retired.
   function automatic logic score_board_check(input logic [REG_FILE_SIZE-1:0] sb,
                                              input reg_id_t id);
      if (is_file_reg(id)) return !sb[reg_num(id)];
      if (id == rsyscall)  return sb == '0;
      return 1'b1;
   endfunction

   function automatic logic mopcode_is_branch(input mopcode_t op);
      return (op == m_jz) || (op == m_jmp);
   endfunction

   function automatic logic mopcode_is_mem(input mopcode_t op);
      return (op == m_ld) || (op == m_st) || (op == m_clflush);
   endfunction

endpackage

// File: rtl/issue_scheduler.sv
// In-order issue controller: register scoreboard, hazard gating, syscall drain,
// branch hold, outstanding memory-op limit and sticky protocol error.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_mop/in_ready  decode-queue handshake (in_ready combinational)
//   out_valid/out_mop/out_ready  registered issue to execute
//   wb0_*/wb1_*             writeback ports clearing scoreboard bits
//   mem_done, br_resolve, flush  completion / branch / flush events
//   sb, err, stall_cnt      scoreboard, sticky error, saturating stall count
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int unsigned MAX_MEM = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  micro_op_t                 in_mop,
   output logic                      in_ready,
   output logic                      out_valid,
   output micro_op_t                 out_mop,
   input  logic                      out_ready,
   input  logic                      wb0_valid,
   input  reg_id_t                   wb0_id,
   input  logic                      wb1_valid,
   input  reg_id_t                   wb1_id,
   input  logic                      mem_done,
   input  logic                      br_resolve,
   input  logic                      flush,
   output logic [REG_FILE_SIZE-1:0]  sb,
   output logic                      err,
   output logic [31:0]               stall_cnt
);

   localparam int unsigned MEM_CNT_W = 4;
   localparam int unsigned MEM_SUM_W = MEM_CNT_W + 1;

   typedef enum logic {st_run, st_br_wait} state_t;

   state_t                   state;
   logic [MEM_CNT_W-1:0]     mem_cnt;

   logic                     hazard_ok;
   logic                     in_is_mem;
   logic                     mem_ok;
   logic                     accept;
   logic                     drop;
   logic [REG_FILE_SIZE-1:0] set_mask;
   logic [REG_FILE_SIZE-1:0] wb_mask;
   logic [REG_FILE_SIZE-1:0] drop_mask;
   logic [REG_FILE_SIZE-1:0] sb_next;
   logic [MEM_SUM_W-1:0]     mem_sum;
   logic [MEM_SUM_W-1:0]     mem_sub;
   logic [MEM_CNT_W-1:0]     mem_next;
   logic                     err_event;

   // Issue decision and next-state terms, all from registered state and in_mop.
   always_comb begin
      hazard_ok = score_board_check(sb, in_mop.src0_id) &&
                  score_board_check(sb, in_mop.src1_id) &&
                  score_board_check(sb, in_mop.dst_id);
      in_is_mem = mopcode_is_mem(in_mop.opcode);
      mem_ok    = !in_is_mem || (mem_cnt < MEM_CNT_W'(MAX_MEM));
      in_ready  = !flush && (state == st_run) && (!out_valid || out_ready) &&
                  hazard_ok && mem_ok;
      accept    = in_valid && in_ready;
      // A flush only retracts a micro-op execute has not taken yet.
      drop      = flush && out_valid && !out_ready;

      set_mask  = accept ? make_sb_mask(in_mop.dst_id) : '0;
      wb_mask   = (wb0_valid ? make_sb_mask(wb0_id) : '0) |
                  (wb1_valid ? make_sb_mask(wb1_id) : '0);
      drop_mask = drop ? make_sb_mask(out_mop.dst_id) : '0;
      // Set is applied last so it wins over a same-cycle clear.
      sb_next   = (sb & ~(wb_mask | drop_mask)) | set_mask;

      mem_sum   = {1'b0, mem_cnt} + MEM_SUM_W'(accept && in_is_mem);
      mem_sub   = MEM_SUM_W'(mem_done && (mem_cnt != '0)) +
                  MEM_SUM_W'(drop && mopcode_is_mem(out_mop.opcode));
      err_event = |(wb_mask & ~sb) || |(set_mask & wb_mask) ||
                  (mem_done && (mem_cnt == '0));
      if (mem_sum < mem_sub) begin
         mem_next  = '0;
         err_event = 1'b1;
      end else begin
         mem_next  = MEM_CNT_W'(mem_sum - mem_sub);
      end
   end

   // State register, issue register, scoreboard, counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= st_run;
         out_valid <= 1'b0;
         out_mop   <= '0;
         sb        <= '0;
         mem_cnt   <= '0;
         err       <= 1'b0;
         stall_cnt <= '0;
      end else begin
         sb      <= sb_next;
         mem_cnt <= mem_next;
         if (err_event) err <= 1'b1;
         if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;

         if (accept) begin
            out_valid <= 1'b1;
            out_mop   <= in_mop;
         end else if (out_ready || drop) begin
            out_valid <= 1'b0;
         end

         if (flush) begin
            state <= st_run;
         end else begin
            case (state)
               st_run:      if (accept && mopcode_is_branch(in_mop.opcode)) state <= st_br_wait;
               st_br_wait:  if (br_resolve) state <= st_run;
               default:     state <= st_run;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler (MAX_MEM=2): a table of hand-derived
// directed vectors followed by randomized traffic against a behavioural model.
module tb_issue_scheduler;
   import issue_scheduler_pkg::*;

   localparam int MAXM = 2;

   logic       clk;
   logic       reset;
   logic       in_valid;
   micro_op_t  in_mop;
   logic       in_ready;
   logic       out_valid;
   micro_op_t  out_mop;
   logic       out_ready;
   logic       wb0_valid;
   reg_id_t    wb0_id;
   logic       wb1_valid;
   reg_id_t    wb1_id;
   logic       mem_done;
   logic       br_resolve;
   logic       flush;
   logic [15:0] sb;
   logic       err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   issue_scheduler #(.MAX_MEM(MAXM)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_mop(in_mop), .in_ready(in_ready),
      .out_valid(out_valid), .out_mop(out_mop), .out_ready(out_ready),
      .wb0_valid(wb0_valid), .wb0_id(wb0_id),
      .wb1_valid(wb1_valid), .wb1_id(wb1_id),
      .mem_done(mem_done), .br_resolve(br_resolve), .flush(flush),
      .sb(sb), .err(err), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic micro_op_t mk(input mopcode_t o, input reg_id_t d, input reg_id_t s0, input reg_id_t s1);
      micro_op_t m;
      m.opcode = o; m.dst_id = d; m.src0_id = s0; m.src1_id = s1; m.imm = 16'h0;
      return m;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit rst; bit iv; micro_op_t mop; bit ordy;
      bit w0v; reg_id_t w0; bit w1v; reg_id_t w1;
      bit md; bit br; bit fl;
      bit e_rdy; bit e_ov; logic [15:0] e_sb; bit e_err; int unsigned e_stall;
   } vec_t;

   vec_t vecs[$];

   task automatic vec(input int rst, input int iv, input micro_op_t mop, input int ordy,
                      input int w0v, input reg_id_t w0, input int w1v, input reg_id_t w1,
                      input int md, input int br, input int fl,
                      input int e_rdy, input int e_ov, input logic [15:0] e_sb,
                      input int e_err, input int unsigned e_stall);
      vec_t v;
      v.rst = (rst != 0); v.iv = (iv != 0); v.mop = mop; v.ordy = (ordy != 0);
      v.w0v = (w0v != 0); v.w0 = w0; v.w1v = (w1v != 0); v.w1 = w1;
      v.md = (md != 0); v.br = (br != 0); v.fl = (fl != 0);
      v.e_rdy = (e_rdy != 0); v.e_ov = (e_ov != 0); v.e_sb = e_sb;
      v.e_err = (e_err != 0); v.e_stall = e_stall;
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; in_mop = mk(m_nop, rnone, rnone, rnone); out_ready = 1'b1;
      wb0_valid = 1'b0; wb0_id = rnone; wb1_valid = 1'b0; wb1_id = rnone;
      mem_done = 1'b0; br_resolve = 1'b0; flush = 1'b0;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      reset = v.rst; in_valid = v.iv; in_mop = v.mop; out_ready = v.ordy;
      wb0_valid = v.w0v; wb0_id = v.w0; wb1_valid = v.w1v; wb1_id = v.w1;
      mem_done = v.md; br_resolve = v.br; flush = v.fl;
      @(negedge clk);
      if (!v.rst) chk("in_ready", idx, 64'(in_ready), 64'(v.e_rdy));
      @(posedge clk); #1;
      chk("out_valid", idx, 64'(out_valid), 64'(v.e_ov));
      chk("sb", idx, 64'(sb), 64'(v.e_sb));
      chk("err", idx, 64'(err), 64'(v.e_err));
      chk("stall_cnt", idx, 64'(stall_cnt), 64'(v.e_stall));
   endtask

   // ---------------- behavioural reference model ----------------
   bit              busy [16];
   int              mem_out;
   bit              br_pend;
   bit              held_v;
   micro_op_t       held;
   bit              m_err;
   longint unsigned m_stall;

   function automatic void model_reset();
      foreach (busy[i]) busy[i] = 1'b0;
      mem_out = 0; br_pend = 1'b0; held_v = 1'b0; held = '0; m_err = 1'b0; m_stall = 0;
   endfunction

   function automatic int file_idx(input reg_id_t id);
      int n;
      n = int'(id);
      return (n < 16) ? n : -1;
   endfunction

   function automatic bit is_mem(input mopcode_t o);
      return o inside {m_ld, m_st, m_clflush};
   endfunction

   function automatic bit id_free(input reg_id_t id);
      int n;
      n = file_idx(id);
      if (n >= 0) return !busy[n];
      if (id == rsyscall) begin
         foreach (busy[i]) if (busy[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit model_ready();
      return !flush && !br_pend && (!held_v || out_ready) &&
             id_free(in_mop.src0_id) && id_free(in_mop.src1_id) && id_free(in_mop.dst_id) &&
             (!is_mem(in_mop.opcode) || mem_out < MAXM);
   endfunction

   function automatic void model_update(input bit rdy);
      bit acc, drop;
      bit cleared [16];
      int n;
      acc  = in_valid && rdy;
      drop = flush && held_v && !out_ready;
      foreach (cleared[i]) cleared[i] = 1'b0;
      if (in_valid && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
      n = file_idx(wb0_id);
      if (wb0_valid && n >= 0) begin if (!busy[n]) m_err = 1'b1; cleared[n] = 1'b1; end
      n = file_idx(wb1_id);
      if (wb1_valid && n >= 0) begin if (!busy[n]) m_err = 1'b1; cleared[n] = 1'b1; end
      if (mem_done) begin
         if (mem_out == 0) m_err = 1'b1; else mem_out--;
      end
      if (drop) begin
         n = file_idx(held.dst_id);
         if (n >= 0) cleared[n] = 1'b1;
         if (is_mem(held.opcode)) begin
            if (mem_out == 0) m_err = 1'b1; else mem_out--;
         end
         held_v = 1'b0;
      end else if (held_v && out_ready) begin
         held_v = 1'b0;
      end
      foreach (busy[i]) if (cleared[i]) busy[i] = 1'b0;
      if (br_resolve) br_pend = 1'b0;
      if (acc) begin
         n = file_idx(in_mop.dst_id);
         if (n >= 0) begin
            if (cleared[n]) m_err = 1'b1;
            busy[n] = 1'b1;
         end
         if (is_mem(in_mop.opcode)) mem_out++;
         held = in_mop; held_v = 1'b1;
         if (in_mop.opcode inside {m_jz, m_jmp}) br_pend = 1'b1;
      end
      if (flush) br_pend = 1'b0;
   endfunction

   function automatic reg_id_t rand_id();
      int r;
      r = int'($urandom_range(0, 11));
      if (r < 8)  return reg_id_t'(5'(r));
      if (r < 11) return rnone;
      return rsyscall;
   endfunction

   task automatic rand_cycle(input int idx);
      int bl[$];
      logic [15:0] exp_sb;
      bit rdy;
      foreach (busy[i]) if (busy[i]) bl.push_back(i);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mop    = mk(mopcode_t'(4'($urandom_range(0, 8))), rand_id(), rand_id(), rand_id());
      in_mop.imm = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      wb0_valid = 1'b0; wb0_id = rnone; wb1_valid = 1'b0; wb1_id = rnone;
      if (bl.size() > 0 && $urandom_range(0, 1) == 1) begin
         wb0_valid = 1'b1; wb0_id = reg_id_t'(5'(bl[$urandom_range(0, bl.size() - 1)]));
      end
      if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
         wb1_valid = 1'b1; wb1_id = reg_id_t'(5'(bl[$urandom_range(0, bl.size() - 1)]));
      end
      if ($urandom_range(0, 299) == 0) begin
         wb1_valid = 1'b1; wb1_id = reg_id_t'(5'($urandom_range(0, 7)));
      end
      mem_done   = (mem_out > ((held_v && is_mem(held.opcode)) ? 1 : 0)) && ($urandom_range(0, 2) == 0);
      br_resolve = br_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      rdy = model_ready();
      chk("rnd in_ready", idx, 64'(in_ready), 64'(rdy));
      model_update(rdy);
      @(posedge clk); #1;
      exp_sb = '0;
      foreach (busy[i]) exp_sb[i] = busy[i];
      chk("rnd out_valid", idx, 64'(out_valid), 64'(held_v));
      if (held_v) chk("rnd out_mop", idx, 64'(out_mop), 64'(held));
      chk("rnd sb", idx, 64'(sb), 64'(exp_sb));
      chk("rnd err", idx, 64'(err), 64'(m_err));
      chk("rnd stall_cnt", idx, 64'(stall_cnt), 64'(m_stall));
   endtask

   initial begin
      micro_op_t idle;
      idle = mk(m_nop, rnone, rnone, rnone);

      // Back-to-back independent adds
      vec(0,1,mk(m_add,rax,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,0);
      vec(0,1,mk(m_add,rbx,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0009,0,0);
      vec(0,0,idle,1,                      1,rax,1,rbx,     0,0,0, 1,0,16'h0000,0,0);
      // RAW hazard: writeback frees the dependent op one cycle later
      vec(0,1,mk(m_add,rax,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,0);
      vec(0,1,mk(m_mov,rcx,rax,rnone),1,   0,rnone,0,rnone, 0,0,0, 0,0,16'h0001,0,1);
      vec(0,1,mk(m_mov,rcx,rax,rnone),1,   1,rax,0,rnone,   0,0,0, 0,0,16'h0000,0,2);
      vec(0,1,mk(m_mov,rcx,rax,rnone),1,   0,rnone,0,rnone, 0,0,0, 1,1,16'h0002,0,2);
      vec(0,0,idle,1,                      1,rcx,0,rnone,   0,0,0, 1,0,16'h0000,0,2);
      // Syscall drain
      vec(0,1,mk(m_add,rax,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,2);
      vec(0,1,mk(m_add,rdx,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0005,0,2);
      vec(0,1,mk(m_syscall,rnone,rsyscall,rnone),1, 0,rnone,0,rnone, 0,0,0, 0,0,16'h0005,0,3);
      vec(0,1,mk(m_syscall,rnone,rsyscall,rnone),1, 1,rax,1,rdx,     0,0,0, 0,0,16'h0000,0,4);
      vec(0,1,mk(m_syscall,rnone,rsyscall,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0000,0,4);
      vec(0,0,idle,1,                      0,rnone,0,rnone, 0,0,0, 1,0,16'h0000,0,4);
      // Memory limit (MAX_MEM=2)
      vec(0,1,mk(m_ld,rax,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,4);
      vec(0,1,mk(m_ld,rbx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0009,0,4);
      vec(0,1,mk(m_ld,rcx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 0,0,16'h0009,0,5);
      vec(0,1,mk(m_ld,rcx,rnone,rnone),1,  0,rnone,0,rnone, 1,0,0, 0,0,16'h0009,0,6);
      vec(0,1,mk(m_ld,rcx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h000B,0,6);
      vec(0,1,mk(m_ld,rdx,rnone,rnone),1,  0,rnone,0,rnone, 1,0,0, 0,0,16'h000B,0,7);
      vec(0,1,mk(m_ld,rdx,rnone,rnone),1,  0,rnone,0,rnone, 1,0,0, 1,1,16'h000F,0,7);
      vec(0,1,mk(m_ld,rsi,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h004F,0,7);
      vec(0,1,mk(m_ld,rdi,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 0,0,16'h004F,0,8);
      vec(0,0,idle,1,                      1,rax,1,rbx,     1,0,0, 1,0,16'h0046,0,8);
      vec(0,0,idle,1,                      1,rcx,1,rdx,     1,0,0, 1,0,16'h0040,0,8);
      vec(0,0,idle,1,                      1,rsi,0,rnone,   0,0,0, 1,0,16'h0000,0,8);
      // Branch hold, then flush of a held memory op
      vec(0,1,mk(m_jz,rnone,rnone,rnone),1, 0,rnone,0,rnone, 0,0,0, 1,1,16'h0000,0,8);
      vec(0,1,mk(m_ld,rax,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 0,0,16'h0000,0,9);
      vec(0,1,mk(m_ld,rax,rnone,rnone),1,  0,rnone,0,rnone, 0,1,0, 0,0,16'h0000,0,10);
      vec(0,1,mk(m_ld,rax,rnone,rnone),0,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,10);
      vec(0,0,idle,0,                      0,rnone,0,rnone, 0,0,1, 0,0,16'h0000,0,10);
      vec(0,1,mk(m_ld,rax,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,0,10);
      vec(0,1,mk(m_ld,rbx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0009,0,10);
      vec(0,1,mk(m_ld,rcx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 0,0,16'h0009,0,11);
      vec(0,0,idle,1,                      1,rax,1,rbx,     1,0,0, 1,0,16'h0000,0,11);
      vec(0,0,idle,1,                      0,rnone,0,rnone, 1,0,0, 1,0,16'h0000,0,11);
      // Errors: clear of an unset register, sticky until reset
      vec(0,0,idle,1,                      0,rnone,1,rdx,   0,0,0, 1,0,16'h0000,1,11);
      vec(0,0,idle,1,                      0,rnone,0,rnone, 0,0,0, 1,0,16'h0000,1,11);
      vec(1,0,idle,1,                      0,rnone,0,rnone, 0,0,0, 1,0,16'h0000,0,0);
      // mem_done with nothing outstanding: err set, count stays 0
      vec(0,0,idle,1,                      0,rnone,0,rnone, 1,0,0, 1,0,16'h0000,1,0);
      vec(0,1,mk(m_ld,rax,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0001,1,0);
      vec(0,1,mk(m_ld,rbx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 1,1,16'h0009,1,0);
      vec(0,1,mk(m_ld,rcx,rnone,rnone),1,  0,rnone,0,rnone, 0,0,0, 0,0,16'h0009,1,1);

      // Reset state
      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 0, 64'(out_valid), 64'd0);
      chk("reset out_mop", 0, 64'(out_mop), 64'd0);
      chk("reset sb", 0, 64'(sb), 64'd0);
      chk("reset err", 0, 64'(err), 64'd0);
      chk("reset stall_cnt", 0, 64'(stall_cnt), 64'd0);
      reset = 1'b0;

      foreach (vecs[i]) apply_vec(i, vecs[i]);

      // Randomized traffic against the model
      drive_idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3000; i++) rand_cycle(i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
